// File: rtl/segre_pkg.sv
// Shared types and helpers for the segre core: ALU opcodes, BHT counter type,
// branch classification.
package segre_pkg;

  localparam int unsigned WORD_SIZE = 32;

  typedef enum logic [4:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl,
    AluSra,
    AluSlt,
    AluSltu,
    AluBeq,
    AluBne,
    AluBlt,
    AluBge,
    AluBltu,
    AluBgeu,
    AluJal,
    AluJalr
  } alu_opcode_e;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t BHT_INIT = 2'b01;

  function automatic logic is_branch(alu_opcode_e op);
    case (op)
      AluBeq, AluBne, AluBlt, AluBge, AluBltu, AluBgeu, AluJal, AluJalr: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/segre_bht.sv
// Branch history table of 2-bit saturating counters; one write port, one
// combinational read port that returns the pre-update value.
module segre_bht
  import segre_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic             taken_i,
  input  logic [IDX_W-1:0] ridx_i,
  output bht_cnt_t         rdata_o
);

  bht_cnt_t bht_q [ENTRIES];
  bht_cnt_t bht_d [ENTRIES];

  assign rdata_o = bht_q[ridx_i];

  always_comb begin
    bht_d = bht_q;
    if (we_i) begin
      if (taken_i && (bht_q[widx_i] != 2'b11)) begin
        bht_d[widx_i] = bht_q[widx_i] + 2'b01;
      end else if (!taken_i && (bht_q[widx_i] != 2'b00)) begin
        bht_d[widx_i] = bht_q[widx_i] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        bht_q[i] <= BHT_INIT;
      end
    end else begin
      bht_q <= bht_d;
    end
  end

endmodule

// File: rtl/segre_tkbr.sv
// Branch direction comparator: taken/not-taken for every branch and jump opcode.
module segre_tkbr
  import segre_pkg::*;
#(
  parameter int unsigned XLEN = WORD_SIZE
) (
  input  alu_opcode_e     alu_opcode_i,
  input  logic [XLEN-1:0] br_src_a_i,
  input  logic [XLEN-1:0] br_src_b_i,
  output logic            tkbr_o
);

  always_comb begin
    tkbr_o = 1'b0;
    case (alu_opcode_i)
      AluBeq:          tkbr_o = (br_src_a_i == br_src_b_i);
      AluBne:          tkbr_o = (br_src_a_i != br_src_b_i);
      AluBlt:          tkbr_o = ($signed(br_src_a_i) < $signed(br_src_b_i));
      AluBge:          tkbr_o = ($signed(br_src_a_i) >= $signed(br_src_b_i));
      AluBltu:         tkbr_o = (br_src_a_i < br_src_b_i);
      AluBgeu:         tkbr_o = (br_src_a_i >= br_src_b_i);
      AluJal, AluJalr: tkbr_o = 1'b1;
      default:         tkbr_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/segre_br_unit.sv
// Registered EX-stage branch resolution: direction, mispredict and redirect one
// cycle after capture, BHT training and statistics on retirement.
module segre_br_unit
  import segre_pkg::*;
#(
  parameter int unsigned XLEN        = WORD_SIZE,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  alu_opcode_e       alu_opcode_i,
  input  logic [XLEN-1:0]   br_src_a_i,
  input  logic [XLEN-1:0]   br_src_b_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   target_i,
  input  logic              pred_taken_i,
  input  logic [XLEN-1:0]   lookup_pc_i,
  output logic              lookup_taken_o,
  output logic              res_valid_o,
  output logic              tkbr_o,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [CNT_W-1:0]  n_branches_o,
  output logic [CNT_W-1:0]  n_mispred_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic             valid_q, valid_d;
  logic             tk_q, tk_d;
  logic             mis_q, mis_d;
  logic             cond_q, cond_d;
  logic [XLEN-1:0]  redir_q, redir_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] n_branches_q, n_branches_d;
  logic [CNT_W-1:0] n_mispred_q, n_mispred_d;

  logic     tk;
  logic     mis;
  logic     retire;
  bht_cnt_t lookup_cnt;
  logic     unused_lookup_bits;

  segre_tkbr #(
    .XLEN (XLEN)
  ) u_tkbr (
    .alu_opcode_i (alu_opcode_i),
    .br_src_a_i   (br_src_a_i),
    .br_src_b_i   (br_src_b_i),
    .tkbr_o       (tk)
  );

  // No BTB: a JALR target is never known at fetch, so it always redirects.
  always_comb begin
    case (alu_opcode_i)
      AluJalr: mis = 1'b1;
      AluJal:  mis = !pred_taken_i;
      default: mis = (tk != pred_taken_i);
    endcase
  end

  assign retire = valid_q & ~stall_i & ~flush_i;

  always_comb begin
    valid_d      = valid_q;
    tk_d         = tk_q;
    mis_d        = mis_q;
    cond_d       = cond_q;
    redir_d      = redir_q;
    idx_d        = idx_q;
    n_branches_d = n_branches_q;
    n_mispred_d  = n_mispred_q;

    if (retire) begin
      if (n_branches_q != {CNT_W{1'b1}}) n_branches_d = n_branches_q + CNT_W'(1);
      if (mis_q && (n_mispred_q != {CNT_W{1'b1}})) n_mispred_d = n_mispred_q + CNT_W'(1);
    end

    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d = valid_i & is_branch(alu_opcode_i);
      // Payload only moves with a real branch so outputs keep their last values.
      if (valid_d) begin
        tk_d    = tk;
        mis_d   = mis;
        cond_d  = (alu_opcode_i != AluJal) && (alu_opcode_i != AluJalr);
        redir_d = tk ? target_i : pc_i + XLEN'(4);
        idx_d   = pc_i[IDX_W+1:2];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      tk_q         <= 1'b0;
      mis_q        <= 1'b0;
      cond_q       <= 1'b0;
      redir_q      <= '0;
      idx_q        <= '0;
      n_branches_q <= '0;
      n_mispred_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      tk_q         <= tk_d;
      mis_q        <= mis_d;
      cond_q       <= cond_d;
      redir_q      <= redir_d;
      idx_q        <= idx_d;
      n_branches_q <= n_branches_d;
      n_mispred_q  <= n_mispred_d;
    end
  end

  segre_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (retire & cond_q),
    .widx_i  (idx_q),
    .taken_i (tk_q),
    .ridx_i  (lookup_pc_i[IDX_W+1:2]),
    .rdata_o (lookup_cnt)
  );

  assign unused_lookup_bits = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0], lookup_cnt[0]};

  assign lookup_taken_o = lookup_cnt[1];
  assign res_valid_o    = valid_q;
  assign tkbr_o         = tk_q;
  assign mispredict_o   = mis_q;
  assign redirect_pc_o  = redir_q;
  assign n_branches_o   = n_branches_q;
  assign n_mispred_o    = n_mispred_q;

endmodule

// File: tb/tb_segre_br_unit.sv
// Randomised and directed checks of segre_br_unit against a behavioural model.
module tb_segre_br_unit;
  import segre_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i, stall_i, flush_i, pred_taken_i;
  alu_opcode_e op;
  logic [31:0] a, b, pc, tgt, lpc;
  logic        lookup_taken_o, res_valid_o, tkbr_o, mispredict_o;
  logic [31:0] redirect_pc_o, n_branches_o, n_mispred_o;

  always #5 clk = ~clk;

  segre_br_unit dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .alu_opcode_i   (op),
    .br_src_a_i     (a),
    .br_src_b_i     (b),
    .pc_i           (pc),
    .target_i       (tgt),
    .pred_taken_i   (pred_taken_i),
    .lookup_pc_i    (lpc),
    .lookup_taken_o (lookup_taken_o),
    .res_valid_o    (res_valid_o),
    .tkbr_o         (tkbr_o),
    .mispredict_o   (mispredict_o),
    .redirect_pc_o  (redirect_pc_o),
    .n_branches_o   (n_branches_o),
    .n_mispred_o    (n_mispred_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  int          m_bht [64];
  logic        m_valid, m_tk, m_mis, m_cond;
  logic [31:0] m_redir, m_nb, m_nm;
  int          m_idx;

  function automatic int idx_of(input logic [31:0] p);
    return int'((p >> 2) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_valid = 0; m_nb = 0; m_nm = 0;
  endtask

  task automatic model_step();
    logic t;
    if (m_valid && !stall_i && !flush_i) begin
      if (m_cond) begin
        if (m_tk && m_bht[m_idx] < 3) m_bht[m_idx]++;
        else if (!m_tk && m_bht[m_idx] > 0) m_bht[m_idx]--;
      end
      if (m_nb != 32'hFFFF_FFFF) m_nb++;
      if (m_mis && m_nm != 32'hFFFF_FFFF) m_nm++;
    end
    if (flush_i) m_valid = 0;
    else if (!stall_i) begin
      m_valid = valid_i && (op inside {AluBeq, AluBne, AluBlt, AluBge, AluBltu, AluBgeu,
                                       AluJal, AluJalr});
      if (m_valid) begin
        case (op)
          AluBeq:  t = (a == b);
          AluBne:  t = (a != b);
          AluBlt:  t = ($signed(a) < $signed(b));
          AluBge:  t = ($signed(a) >= $signed(b));
          AluBltu: t = (a < b);
          AluBgeu: t = (a >= b);
          default: t = 1;
        endcase
        m_tk    = t;
        m_cond  = !(op inside {AluJal, AluJalr});
        m_mis   = (op == AluJalr) ? 1'b1 : (op == AluJal) ? !pred_taken_i : (t != pred_taken_i);
        m_redir = t ? tgt : pc + 32'd4;
        m_idx   = idx_of(pc);
      end
    end
  endtask

  task automatic tick();
    #1;
    check_eq("lookup", {31'b0, lookup_taken_o}, {31'b0, m_bht[idx_of(lpc)] >= 2});
    @(posedge clk);
    model_step();
    #1;
    check_eq("res_valid", {31'b0, res_valid_o}, {31'b0, m_valid});
    check_eq("n_branches", n_branches_o, m_nb);
    check_eq("n_mispred", n_mispred_o, m_nm);
    if (m_valid) begin
      check_eq("tkbr", {31'b0, tkbr_o}, {31'b0, m_tk});
      check_eq("mispredict", {31'b0, mispredict_o}, {31'b0, m_mis});
      check_eq("redirect", redirect_pc_o, m_redir);
    end
  endtask

  task automatic drive(input alu_opcode_e o, input logic [31:0] sa, input logic [31:0] sb,
                       input logic [31:0] p, input logic [31:0] t, input logic pr);
    valid_i = 1; stall_i = 0; flush_i = 0;
    op = o; a = sa; b = sb; pc = p; tgt = t; pred_taken_i = pr;
  endtask

  task automatic idle();
    valid_i = 0; stall_i = 0; flush_i = 0;
  endtask

  initial begin
    rst_i = 1; lpc = 32'h100; op = AluAdd; a = 0; b = 0; pc = 0; tgt = 0; pred_taken_i = 0;
    idle();
    model_reset();
    #3;
    check_eq("rst_res_valid", {31'b0, res_valid_o}, 32'd0);
    check_eq("rst_tkbr", {31'b0, tkbr_o}, 32'd0);
    check_eq("rst_mispredict", {31'b0, mispredict_o}, 32'd0);
    check_eq("rst_redirect", redirect_pc_o, 32'd0);
    check_eq("rst_n_br", n_branches_o, 32'd0);
    check_eq("rst_n_mp", n_mispred_o, 32'd0);
    @(posedge clk); #1;
    rst_i = 0;

    // Signed vs unsigned compare on the same operands
    drive(AluBlt, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h400, 1'b0);
    tick();
    check_eq("blt_tk", {31'b0, tkbr_o}, 32'd1);
    check_eq("blt_redir", redirect_pc_o, 32'h400);
    drive(AluBltu, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h400, 1'b0);
    tick();
    check_eq("bltu_mis", {31'b0, mispredict_o}, 32'd0);
    check_eq("bltu_redir", redirect_pc_o, 32'h204);

    // Train BEQ at 0x100 to saturation
    lpc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      drive(AluBeq, 32'd7, 32'd7, 32'h100, 32'h80, 1'b1);
      tick();
    end
    idle();
    tick();
    check_eq("bht_trained", {31'b0, lookup_taken_o}, 32'd1);

    // Mid-stream async reset with a result in flight
    drive(AluBne, 32'd1, 32'd2, 32'h104, 32'h90, 1'b0);
    tick();
    rst_i = 1;
    model_reset();
    #1;
    check_eq("mrst_res_valid", {31'b0, res_valid_o}, 32'd0);
    check_eq("mrst_n_br", n_branches_o, 32'd0);
    check_eq("mrst_n_mp", n_mispred_o, 32'd0);
    for (int i = 0; i < 4; i++) begin
      lpc = 32'h100 + 32'(i * 4);
      #1;
      check_eq("mrst_lookup", {31'b0, lookup_taken_o}, 32'd0);
    end
    rst_i = 0;
    idle();
    lpc = 32'h100;
    tick();

    // Saturate then four not-taken retirements return lookup to not-taken
    for (int i = 0; i < 4; i++) begin
      drive(AluBeq, 32'd3, 32'd3, 32'h100, 32'h80, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(AluBeq, 32'd3, 32'd4, 32'h100, 32'h80, 1'b1);
      tick();
    end
    idle();
    tick();
    check_eq("bht_untrained", {31'b0, lookup_taken_o}, 32'd0);

    // Stall for three cycles with a valid BNE
    drive(AluBne, 32'd5, 32'd6, 32'h300, 32'h500, 1'b0);
    tick();
    idle();
    stall_i = 1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("stall_redir", redirect_pc_o, 32'h500);
    stall_i = 0;
    tick();

    // Flush with incoming valid, and flush of a valid stage
    drive(AluBeq, 32'd1, 32'd1, 32'h100, 32'h40, 1'b0);
    flush_i = 1;
    tick();
    drive(AluBeq, 32'd1, 32'd1, 32'h100, 32'h40, 1'b0);
    tick();
    idle();
    flush_i = 1;
    tick();
    idle();
    tick();

    // Top-of-memory PC: JALR mispredict and wrapping fall-through
    drive(AluJalr, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h1000, 1'b1);
    tick();
    check_eq("jalr_mis", {31'b0, mispredict_o}, 32'd1);
    drive(AluBeq, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h1000, 1'b0);
    tick();
    check_eq("wrap_redir", redirect_pc_o, 32'h0000_0000);
    idle();
    tick();

    // Counter saturation
    force dut.n_branches_q = 32'hFFFF_FFFF;
    force dut.n_mispred_q = 32'hFFFF_FFFF;
    #1;
    release dut.n_branches_q;
    release dut.n_mispred_q;
    m_nb = 32'hFFFF_FFFF;
    m_nm = 32'hFFFF_FFFF;
    drive(AluJalr, 32'd0, 32'd0, 32'h40, 32'h60, 1'b1);
    tick();
    idle();
    tick();
    check_eq("sat_n_br", n_branches_o, 32'hFFFF_FFFF);
    check_eq("sat_n_mp", n_mispred_o, 32'hFFFF_FFFF);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      op = alu_opcode_e'(5'($urandom_range(0, 17)));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 7)) - 32'd4;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom_range(0, 7)) - 32'd4;
      pc = 32'($urandom_range(0, 255)) << 2;
      tgt = $urandom;
      pred_taken_i = 1'($urandom_range(0, 1));
      lpc = 32'($urandom_range(0, 255)) << 2;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/segre_br_unit.md
Name: segre_br_unit

Overview:
- Registered branch-resolution unit for the EX stage, generalising the combinational taken-branch comparator.
- Per branch it resolves the direction for all RV32 branch/jump opcodes, compares it with the fetch-time prediction, and produces a redirect PC with a mispredict flag one cycle later.
- Owns a PC-indexed table of 2-bit saturating counters (BHT); the fetch stage reads it combinationally.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- XLEN, 32 (WORD_SIZE): width of operands, PCs and targets.
- BHT_ENTRIES, 64: number of counters; must be a power of 2 and at least 2. IDX_W = $clog2(BHT_ENTRIES).
- CNT_W, 32: width of each statistics counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  EX presents an instruction
- stall_i  in  1  hold the resolution stage
- flush_i  in  1  kill the stage contents
- alu_opcode_i  in  alu_opcode_e  operation
- br_src_a_i  in  XLEN  rs1 value
- br_src_b_i  in  XLEN  rs2 value
- pc_i  in  XLEN  branch PC
- target_i  in  XLEN  taken target computed by the ALU
- pred_taken_i  in  1  prediction carried from fetch
- lookup_pc_i  in  XLEN  fetch PC for BHT read
- lookup_taken_o  out  1  predicted direction (counter MSB), combinational
- res_valid_o  out  1  resolution result valid
- tkbr_o  out  1  resolved taken
- mispredict_o  out  1  fetch must be redirected
- redirect_pc_o  out  XLEN  correct next PC
- n_branches_o  out  CNT_W  resolved branches and jumps
- n_mispred_o  out  CNT_W  mispredicts

Behaviour:
- Reset:
  - res_valid_o, tkbr_o, mispredict_o = 0; redirect_pc_o = 0.
  - Both statistics counters = 0.
  - Every BHT counter = 2'b01 (weakly not-taken).
- Branch classification: is_br = opcode ∈ {BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR}. Any other opcode is never captured.
- Direction:
  - BEQ/BNE use equality.
  - BLT/BGE use signed XLEN compare.
  - BLTU/BGEU use unsigned XLEN compare.
  - JAL/JALR are always taken.
- Stage update at posedge, in priority order:
  1. flush_i: stage valid is cleared. Flush overrides stall and new input.
  2. stall_i: all stage registers hold; the BHT and counters do not update.
  3. Otherwise the stage captures valid_i & is_br, together with the computed direction, mispredict and redirect values.
- Latency: exactly 1 cycle from sampling valid_i to res_valid_o. While stalled, res_valid_o stays high for as many cycles as the stall lasts, with the same payload.
- Redirect PC: tk ? target_i : pc_i + 4, computed modulo 2^XLEN, so the increment wraps.
- Mispredict:
  - Conditional branches: tk != pred_taken_i.
  - JAL: !pred_taken_i.
  - JALR: always 1, because no BTB exists.
- Outputs tkbr_o, mispredict_o and redirect_pc_o are meaningful only while res_valid_o = 1. They keep their last values otherwise.
- Retirement: a resolution retires on the cycle where res_valid_o = 1, stall_i = 0 and flush_i = 0.
- On each retirement:
  - The BHT entry at index stage_pc[IDX_W+1:2] updates, for conditional opcodes only: taken increments saturating at 3, not-taken decrements saturating at 0. JAL/JALR never touch the BHT.
  - n_branches_o increments, saturating at all-ones.
  - n_mispred_o increments when mispredict_o = 1, saturating at all-ones.
- BHT read: index lookup_pc_i[IDX_W+1:2]. On a same-cycle read and write to the same entry, the read returns the pre-update value.
- Asynchronous reset mid-operation drops any in-flight result; no update occurs for it.

Decomposition:
- segre_pkg gains:
  - BHT_INIT = 2'b01
  - bht_cnt_t (logic [1:0])
  - the is_branch(alu_opcode_e) function
- The direction compare is a sub-module: segre_tkbr, reused unchanged with port widths generalised to XLEN.
- The BHT is a separate sub-module: segre_bht (array plus saturating update, 1 write port and 1 read port).

Test Plan:
- Reset: assert rst_i mid-stream → res_valid_o = 0 and both counters = 0; for any lookup_pc_i, lookup_taken_o = 0.
- BLT, a = 0xFFFFFFFF, b = 1, pred = 0 → next cycle tkbr_o = 1, mispredict_o = 1, redirect_pc_o = target_i. The same operands with BLTU → tk = 0, mispredict_o = 0, redirect_pc_o = pc_i + 4.
- BEQ at pc = 0x100, taken three times in a row with no stall → the lookup at 0x100 flips to 1 after the first retirement; the counter saturates at 3; four not-taken retirements afterwards return lookup to 0.
- stall_i held for 3 cycles with a valid BNE → res_valid_o high for 4 cycles with a stable payload; n_branches_o increments exactly once.
- flush_i on the same cycle as valid_i, and flush_i while the stage is valid → res_valid_o = 0 next cycle; no BHT or counter change.
- JALR with pred = 1 at pc = 0xFFFFFFFC → mispredict_o = 1. A not-taken branch at that PC gives redirect_pc_o = 0x00000000 (wrap). Counters preloaded via force to all-ones do not wrap.
